// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generation, inst SRAM request, decode handoff.
// Optional address-fault detection is compiled in with FETCH_ADEF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
`ifdef FETCH_ADEF_EN
    , parameter logic [31:0] NOP_INST = 32'h0340_0000
`endif
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic [31:0] instD,
    output logic [31:0] pcD,
    output logic        validD
`ifdef FETCH_ADEF_EN
    , output logic      adefD
`endif
);

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        buf_valid;
    logic [31:0] inst_buf;
    logic        fs_allowin;
    logic [31:0] nextpc;
    logic [31:0] live_inst;

    assign nextpc    = br_taken ? br_target : fs_pc + 32'd4;
    assign live_inst = buf_valid ? inst_buf : inst_sram_rdata;

`ifdef FETCH_ADEF_EN
    logic fs_adef;
    logic misalign;

    assign misalign     = |nextpc[1:0];
    assign fs_allowin   = fs_adef ? br_taken
                                  : (~fs_valid | id_allowin | br_taken);
    assign inst_sram_en = resetn & fs_allowin & ~misalign;
    assign instD        = fs_adef ? NOP_INST : live_inst;
    assign adefD        = validD & fs_adef;
`else
    assign fs_allowin   = ~fs_valid | id_allowin | br_taken;
    assign inst_sram_en = resetn & fs_allowin;
    assign instD        = live_inst;
`endif

    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'd0;
    assign pcD             = fs_pc;
    assign validD          = resetn & fs_valid & ~br_taken;

    // Advance the IF entry on acceptance; otherwise hold it and
    // capture the returning SRAM word once so it survives the stall.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_valid  <= 1'b0;
            fs_pc     <= RESET_PC - 32'd4;
            buf_valid <= 1'b0;
            inst_buf  <= 32'd0;
`ifdef FETCH_ADEF_EN
            fs_adef   <= 1'b0;
`endif
        end else if (fs_allowin) begin
            fs_valid  <= 1'b1;
            fs_pc     <= nextpc;
            buf_valid <= 1'b0;
`ifdef FETCH_ADEF_EN
            fs_adef   <= misalign;
`endif
        end else if (!buf_valid) begin
            inst_buf  <= inst_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

endmodule
